// File: rtl/instr_encoder.sv
// Sequential instruction encoder: packs field-level requests into 32-bit decoder-format
// words and writes them in order into instruction memory through a single write port.
module instr_encoder #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        kind,
   input  logic [3:0]        cond,
   input  logic [3:0]        cmd,
   input  logic              s,
   input  logic              load,
   input  logic [3:0]        rn,
   input  logic [3:0]        rd,
   input  logic [3:0]        rm,
   input  logic [31:0]       imm,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wd,
   output logic              full,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, SEARCH, EMIT, ERR} state_t;

   state_t            state;
   logic [ADDR_W-1:0] wr_ptr;

   // request fields kept for the immediate rotation search
   logic [3:0]        l_cond;
   logic [3:0]        l_cmd;
   logic              l_s;
   logic [3:0]        l_rn;
   logic [3:0]        l_rd;
   logic [31:0]       cand;
   logic [3:0]        rot;

   logic              hs;
   logic              direct_ok;
   logic [31:0]       direct_word;
   logic [31:0]       mag;
   logic              hit;
   logic [31:0]       search_word;

   function automatic logic cmd_legal(input logic [3:0] c);
      return (c == 4'b0000) || (c == 4'b0010) || (c == 4'b0100) ||
             (c == 4'b1100) || (c == 4'b1010);
   endfunction

   // CMP always sets flags and has no destination register
   function automatic logic [31:0] dp_word(input logic [3:0]  c_cond,
                                           input logic [3:0]  c_cmd,
                                           input logic        c_s,
                                           input logic [3:0]  c_rn,
                                           input logic [3:0]  c_rd,
                                           input logic        i_bit,
                                           input logic [11:0] op2);
      logic is_cmp;
      is_cmp = (c_cmd == 4'b1010);
      return {c_cond, 2'b00, i_bit, c_cmd, c_s | is_cmp, c_rn,
              is_cmp ? 4'b0000 : c_rd, op2};
   endfunction

   assign in_ready = (state == IDLE) & ~full & ~clr;
   assign hs       = in_valid & in_ready;

   always_comb begin
      mag         = imm[31] ? (~imm + 32'd1) : imm;
      direct_ok   = 1'b0;
      direct_word = '0;
      case (kind)
         2'b00: begin
            direct_ok   = cmd_legal(cmd);
            direct_word = dp_word(cond, cmd, s, rn, rd, 1'b0, {8'h00, rm});
         end
         2'b10: begin
            direct_ok   = (mag <= 32'd4095);
            direct_word = {cond, 2'b01, 1'b0, 1'b1, ~imm[31], 1'b0, 1'b0, load,
                           rn, rd, mag[11:0]};
         end
         2'b11: begin
            direct_ok   = (imm[31:23] == '0) || (imm[31:23] == '1);
            direct_word = {cond, 4'b1010, imm[23:0]};
         end
         default: ;
      endcase
      hit         = (cand[31:8] == '0);
      search_word = dp_word(l_cond, l_cmd, l_s, l_rn, l_rd, 1'b1, {rot, cand[7:0]});
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_wd   <= '0;
         full     <= 1'b0;
         err      <= 1'b0;
         l_cond   <= '0;
         l_cmd    <= '0;
         l_s      <= 1'b0;
         l_rn     <= '0;
         l_rd     <= '0;
         cand     <= '0;
         rot      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (clr) begin
                  wr_ptr <= '0;
                  full   <= 1'b0;
                  err    <= 1'b0;
               end else if (hs) begin
                  l_cond <= cond;
                  l_cmd  <= cmd;
                  l_s    <= s;
                  l_rn   <= rn;
                  l_rd   <= rd;
                  cand   <= imm;
                  rot    <= '0;
                  if (kind == 2'b01) begin
                     state <= SEARCH;
                  end else if (direct_ok) begin
                     mem_we   <= 1'b1;
                     mem_addr <= wr_ptr;
                     mem_wd   <= direct_word;
                     state    <= EMIT;
                  end else begin
                     state <= ERR;
                  end
               end
            end
            SEARCH: begin
               // cand holds imm ROL 2*rot; the first fit gives the smallest rotation
               if (hit) begin
                  if (cmd_legal(l_cmd)) begin
                     mem_we   <= 1'b1;
                     mem_addr <= wr_ptr;
                     mem_wd   <= search_word;
                     state    <= EMIT;
                  end else begin
                     state <= ERR;
                  end
               end else if (rot == 4'd15) begin
                  state <= ERR;
               end else begin
                  rot  <= rot + 4'd1;
                  cand <= {cand[29:0], cand[31:30]};
               end
            end
            EMIT: begin
               mem_we <= 1'b0;
               if (&wr_ptr) full <= 1'b1;
               else         wr_ptr <= wr_ptr + ADDR_W'(1);
               state <= IDLE;
            end
            ERR: begin
               err   <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: transaction-level reference model (per-request outcome and
// latency), a per-cycle output compare, directed literal cases and random traffic.
module tb_instr_encoder;
   localparam int AW    = 2;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          clr = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [1:0]    kind = '0;
   logic [3:0]    cond = '0, cmd = '0, rn = '0, rd = '0, rm = '0;
   logic          s = 1'b0, load = 1'b0;
   logic [31:0]   imm = '0;
   logic          mem_we, full, err;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wd;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   instr_encoder #(.ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
      .kind(kind), .cond(cond), .cmd(cmd), .s(s), .load(load),
      .rn(rn), .rd(rd), .rm(rm), .imm(imm),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .full(full), .err(err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic bit legal_cmd(input logic [3:0] c);
      return c == 4'h0 || c == 4'h2 || c == 4'h4 || c == 4'hC || c == 4'hA;
   endfunction

   // Outcome of one request: ok (write vs error), word, and cycles from handshake to action
   task automatic model_req(input logic [1:0] k, input logic [3:0] cd, cm, input logic sb, ld,
                            input logic [3:0] n, d, m, input logic [31:0] im,
                            output bit ok, output logic [31:0] w, output int dly);
      longint off, mag;
      logic [63:0] dbl;
      logic [31:0] c, hdr;
      int hit;
      bit is_cmp;
      is_cmp = (cm == 4'hA);
      off = $signed(im);
      hdr = (32'(cd) << 28) | (32'(cm) << 21) | (32'(is_cmp ? 1'b1 : sb) << 20) |
            (32'(n) << 16) | (32'(is_cmp ? 4'h0 : d) << 12);
      w = '0; ok = 0; dly = 1;
      case (k)
         2'b00: begin ok = legal_cmd(cm); w = hdr | 32'(m); end
         2'b01: begin
            hit = -1;
            dbl = {im, im};
            for (int r = 0; r < 16; r++) begin
               c = dbl[(32 - 2*r) +: 32];
               if (hit < 0 && c < 32'd256) begin
                  hit = r;
                  w = hdr | 32'h0200_0000 | (32'(r) << 8) | c;
               end
            end
            if (hit < 0) begin ok = 0; dly = 17; end
            else begin ok = legal_cmd(cm); dly = 2 + hit; end
         end
         2'b10: begin
            mag = (off < 0) ? -off : off;
            ok = (mag <= 4095);
            w = (32'(cd) << 28) | 32'h0500_0000 | ((off >= 0) ? 32'h0080_0000 : 32'h0) |
                (32'(ld) << 20) | (32'(n) << 16) | (32'(d) << 12) | (32'(mag) & 32'hFFF);
         end
         default: begin
            ok = (off >= -(64'sd1 << 23)) && (off < (64'sd1 << 23));
            w = (32'(cd) << 28) | 32'h0A00_0000 | (im & 32'h00FF_FFFF);
         end
      endcase
   endtask

   // Model state: cycles until the current request acts, pointer, flags, last write
   int          m_busy = 0;
   bit          m_write = 0;
   logic [31:0] m_word = '0;
   int          m_ptr = 0;
   bit          m_full = 0, m_err = 0;
   int          last_addr = 0;
   logic [31:0] last_wd = '0;
   int          hs_count = 0;
   bit          checking = 0;
   bit          mr_ok;
   logic [31:0] mr_w;
   int          mr_d;

   always @(posedge clk) begin
      if (reset) begin
         m_busy = 0; m_write = 0; m_ptr = 0; m_full = 0; m_err = 0;
         last_addr = 0; last_wd = '0;
      end else if (m_busy > 0) begin
         if (m_busy == 1) begin
            if (m_write) begin
               last_addr = m_ptr;
               last_wd   = m_word;
               if (m_ptr == DEPTH - 1) m_full = 1;
               else m_ptr++;
            end else begin
               m_err = 1;
            end
         end
         m_busy--;
      end else if (clr) begin
         m_ptr = 0; m_full = 0; m_err = 0;
      end else if (in_valid && !m_full) begin
         model_req(kind, cond, cmd, s, load, rn, rd, rm, imm, mr_ok, mr_w, mr_d);
         m_busy  = mr_d;
         m_write = mr_ok;
         m_word  = mr_w;
         hs_count++;
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         bit e_we;
         e_we = (m_busy == 1) && m_write;
         chk("mem_we", 32'(mem_we), 32'(e_we));
         chk("mem_addr", 32'(mem_addr), e_we ? 32'(m_ptr) : 32'(last_addr));
         chk("mem_wd", mem_wd, e_we ? m_word : last_wd);
         chk("full", 32'(full), 32'(m_full));
         chk("err", 32'(err), 32'(m_err));
         chk("in_ready", 32'(in_ready), 32'(m_busy == 0 && !m_full && !clr));
      end
   end

   task automatic set_fields(input logic [1:0] k, input logic [3:0] cd, cm, input logic sb, ld,
                             input logic [3:0] n, d, m, input logic [31:0] im);
      kind = k; cond = cd; cmd = cm; s = sb; load = ld; rn = n; rd = d; rm = m; imm = im;
   endtask

   task automatic wait_hs(input string name);
      int n0;
      n0 = hs_count;
      for (int i = 0; i < 40 && hs_count == n0; i++) begin
         @(posedge clk); #1;
      end
      in_valid = 0;
      chk({name, " handshake"}, 32'(hs_count != n0), 32'd1);
   endtask

   task automatic send(input string name, input logic [1:0] k, input logic [3:0] cd, cm,
                       input logic sb, ld, input logic [3:0] n, d, m, input logic [31:0] im);
      set_fields(k, cd, cm, sb, ld, n, d, m, im);
      in_valid = 1;
      wait_hs(name);
   endtask

   task automatic expect_write(input string name, input logic [31:0] word, input int lat,
                               input int addr);
      int seen;
      seen = 0;
      for (int i = 1; i <= 30 && seen == 0; i++) begin
         @(negedge clk);
         if (mem_we === 1'b1) seen = i;
      end
      chk({name, " latency"}, 32'(seen), 32'(lat));
      chk({name, " word"}, mem_wd, word);
      chk({name, " addr"}, 32'(mem_addr), 32'(addr));
   endtask

   task automatic expect_err(input string name, input int lat);
      int seen, writes;
      seen = 0; writes = 0;
      for (int i = 1; i <= 30 && seen == 0; i++) begin
         @(negedge clk);
         if (mem_we === 1'b1) writes++;
         if (err === 1'b1) seen = i;
      end
      chk({name, " err latency"}, 32'(seen), 32'(lat));
      chk({name, " no write"}, 32'(writes), 32'd0);
   endtask

   task automatic pin(input string name, input logic [1:0] k, input logic [3:0] cd, cm,
                      input logic sb, ld, input logic [3:0] n, d, m, input logic [31:0] im,
                      input bit e_ok, input logic [31:0] e_w, input int e_d);
      bit ok; logic [31:0] w; int dl;
      model_req(k, cd, cm, sb, ld, n, d, m, im, ok, w, dl);
      chk({name, " model ok"}, 32'(ok), 32'(e_ok));
      if (e_ok) chk({name, " model word"}, w, e_w);
      chk({name, " model delay"}, 32'(dl), 32'(e_d));
   endtask

   task automatic pulse_clr();
      clr = 1; @(negedge clk); clr = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk); #1 checking = 1;
      @(posedge clk); #1 reset = 0;
      @(negedge clk);
      chk("reset mem_we", 32'(mem_we), 32'd0);
      chk("reset mem_addr", 32'(mem_addr), 32'd0);
      chk("reset mem_wd", mem_wd, 32'd0);
      chk("reset full", 32'(full), 32'd0);
      chk("reset err", 32'(err), 32'd0);
      chk("reset in_ready", 32'(in_ready), 32'd1);

      pin("add",  2'b00, 4'hE, 4'h4, 0, 0, 4'd2, 4'd1, 4'd3, 32'h0, 1, 32'hE0821003, 1);
      pin("sub",  2'b01, 4'hE, 4'h2, 0, 0, 4'd0, 4'd0, 4'd0, 32'hFF000000, 1, 32'hE24004FF, 6);
      pin("cmp",  2'b01, 4'hE, 4'hA, 0, 0, 4'd2, 4'd7, 4'd0, 32'd5, 1, 32'hE3520005, 2);
      pin("miss", 2'b01, 4'hE, 4'h4, 0, 0, 4'd1, 4'd1, 4'd0, 32'h101, 0, 32'h0, 17);
      pin("ldr",  2'b10, 4'hE, 4'h0, 0, 1, 4'd5, 4'd4, 4'd0, -32'sd8, 1, 32'hE5154008, 1);
      pin("str",  2'b10, 4'hE, 4'h0, 0, 0, 4'd5, 4'd4, 4'd0, 32'd4096, 0, 32'h0, 1);
      pin("b",    2'b11, 4'h0, 4'h0, 0, 0, 4'd0, 4'd0, 4'd0, -32'sd2, 1, 32'h0AFFFFFE, 1);
      pin("bbig", 2'b11, 4'h0, 4'h0, 0, 0, 4'd0, 4'd0, 4'd0, 32'h00800000, 0, 32'h0, 1);

      send("add", 2'b00, 4'hE, 4'h4, 0, 0, 4'd2, 4'd1, 4'd3, 32'h0);
      expect_write("add", 32'hE0821003, 1, 0);
      send("sub", 2'b01, 4'hE, 4'h2, 0, 0, 4'd0, 4'd0, 4'd0, 32'hFF000000);
      expect_write("sub", 32'hE24004FF, 6, 1);
      send("cmp", 2'b01, 4'hE, 4'hA, 0, 0, 4'd2, 4'd7, 4'd0, 32'd5);
      expect_write("cmp", 32'hE3520005, 2, 2);
      send("miss", 2'b01, 4'hE, 4'h4, 0, 0, 4'd1, 4'd1, 4'd0, 32'h101);
      expect_err("miss", 18);
      send("ldr", 2'b10, 4'hE, 4'h0, 0, 1, 4'd5, 4'd4, 4'd0, -32'sd8);
      expect_write("ldr", 32'hE5154008, 1, 3);

      // memory now full: a pending request waits until clr
      set_fields(2'b11, 4'h0, 4'h0, 0, 0, 4'd0, 4'd0, 4'd0, -32'sd2);
      in_valid = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("full held", 32'(full), 32'd1);
         chk("full no ready", 32'(in_ready), 32'd0);
      end
      pulse_clr();
      wait_hs("held b");
      expect_write("held b", 32'h0AFFFFFE, 1, 0);
      chk("clr cleared err", 32'(err), 32'd0);

      send("str", 2'b10, 4'hE, 4'h0, 0, 0, 4'd5, 4'd4, 4'd0, 32'd4096);
      expect_err("str", 2);
      pulse_clr();
      send("bbig", 2'b11, 4'h0, 4'h0, 0, 0, 4'd0, 4'd0, 4'd0, 32'h00800000);
      expect_err("bbig", 2);
      pulse_clr();

      send("rst search", 2'b01, 4'hE, 4'h4, 0, 0, 4'd1, 4'd1, 4'd0, 32'h101);
      repeat (3) @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("rst search no write", 32'(mem_we), 32'd0);
      end
      chk("rst mem_addr", 32'(mem_addr), 32'd0);
      chk("rst mem_wd", mem_wd, 32'd0);
      chk("rst full", 32'(full), 32'd0);
      chk("rst err", 32'(err), 32'd0);
      chk("rst in_ready", 32'(in_ready), 32'd1);

      for (int cyc = 0; cyc < 4000; cyc++) begin
         logic [1:0]  k;
         logic [31:0] x;
         logic [63:0] dd;
         int sel;
         @(posedge clk); #1;
         reset    = ($urandom_range(0, 299) == 0);
         clr      = ($urandom_range(0, 11) == 0);
         in_valid = ($urandom_range(0, 9) < 6);
         k = 2'($urandom_range(0, 3));
         kind = k;
         cond = 4'($urandom);
         cmd  = ($urandom_range(0, 9) < 8) ?
                ((sel = $urandom_range(0, 4)) == 0 ? 4'h0 : sel == 1 ? 4'h2 :
                 sel == 2 ? 4'h4 : sel == 3 ? 4'hC : 4'hA) : 4'($urandom);
         s = 1'($urandom); load = 1'($urandom);
         rn = 4'($urandom); rd = 4'($urandom); rm = 4'($urandom);
         sel = $urandom_range(0, 2);
         case (k)
            2'b01: begin
               if (sel == 0) begin
                  x  = 32'($urandom_range(0, 255));
                  dd = {x, x};
                  imm = dd[2*$urandom_range(0, 15) +: 32];
               end else if (sel == 1) imm = $urandom;
               else imm = 32'($urandom_range(0, 1023));
            end
            2'b10: imm = 32'($urandom_range(0, 8400)) - 32'd4200;
            2'b11: begin
               if (sel == 0) imm = 32'($urandom_range(0, 200)) - 32'd100;
               else if (sel == 1) imm = 32'h007F_FFFC + 32'($urandom_range(0, 8));
               else imm = 32'hFF80_0004 - 32'($urandom_range(0, 8));
            end
            default: imm = $urandom;
         endcase
      end
      @(posedge clk); #1;
      reset = 0; clr = 0; in_valid = 0;
      repeat (25) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
